alu_rs: RTL and testbench
=========================

ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8, number of reservation-station entries (power of two, 2..16).
REQ-002 SHALL have parameter ROB_WIDTH, default 4, width of ROB tags.
REQ-003 SHALL have port clk_in  input  1  clock; all state on rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports rdy_in input 1 (global enable, low = hold all state) and clear input 1 (mispredict flush).
REQ-006 SHALL have dispatch inputs: in_valid 1; in_op 4 (ALU op code); in_vj 32; in_vk 32; in_qj_busy 1; in_qj ROB_WIDTH; in_qk_busy 1; in_qk ROB_WIDTH; in_rob_id ROB_WIDTH.
REQ-007 SHALL have output full 1: high when every entry is busy.
REQ-008 SHALL have CDB inputs: cdb_valid 1; cdb_rob_id ROB_WIDTH; cdb_value 32.
REQ-009 SHALL have ALU-side outputs: cal 1; a 32; b 32; alu_op 4; issue_rob_id ROB_WIDTH; all registered.

Function
REQ-010 SHALL hold per entry: busy, op, vj, vk, qj_busy, qj, qk_busy, qk, rob_id.
REQ-011 SHALL write the lowest-index free entry when rdy_in & in_valid & !full; in_valid while full SHALL be ignored.
REQ-012 SHALL, at insert, clear qj_busy/qk_busy and capture cdb_value when cdb_valid and cdb_rob_id equals the incoming pending tag (same-cycle capture, never lost).
REQ-013 SHALL, each enabled cycle, clear qj_busy (qk_busy) and load vj (vk) from cdb_value in every busy entry whose pending tag matches cdb_rob_id.
REQ-014 SHALL deem an entry ready when busy & !qj_busy & !qk_busy; select the lowest-index ready entry.
REQ-015 SHALL, on selection, register cal=1, a=vj, b=vk, alu_op=op, issue_rob_id=rob_id next edge and free that entry; cal=0 when nothing ready.
REQ-016 SHALL issue at most one entry per cycle; latency insert-to-cal with operands ready = 1 cycle after the insert edge (entry visible next cycle, issued on the following edge).
REQ-017 SHALL allow insert and issue in the same cycle; a slot freed by issue becomes available the following cycle (full computed from current busy bits only).
REQ-018 SHALL, when rdy_in=0, hold all entries and outputs unchanged, including cal.
REQ-019 SHALL, when rdy_in & clear, clear all busy bits and drive cal=0 next edge; simultaneous insert/CDB are discarded; clear dominates.

Reset
REQ-020 SHALL, while rst_in high, asynchronously force all busy=0, cal=0, a=0, b=0, alu_op=0, issue_rob_id=0; full=0.
REQ-021 SHALL resume normal operation on the first rising edge after rst_in falls; reset mid-operation drops all entries.

Configuration
REQ-022 SHALL support macro ALU_RS_WAKEUP_BYPASS_EN.
REQ-023 With ALU_RS_WAKEUP_BYPASS_EN defined, SHALL treat an entry whose last pending operand matches this cycle's CDB as ready this cycle, forwarding cdb_value into a/b.
REQ-024 Without it, SHALL make a CDB-woken entry eligible no earlier than the next cycle (one extra cycle latency).

Structure
REQ-025 SHALL take ALU op encodings (ADD..SLTU, 4-bit) and the RS entry struct from the shared CPU package.
REQ-026 SHALL implement selection in one sub-module rs_pick: priority encoder (busy/ready vector -> index + valid), used twice (free slot, ready entry).

Verification
REQ-027 Reset: rst_in=1 mid-run with 3 busy entries -> cal=0, full=0 immediately; after release no stale issue.
REQ-028 Ready insert: op=ADD, vj=5, vk=7, no deps -> two edges later cal=1, a=5, b=7, alu_op=0000, issue_rob_id=in_rob_id.
REQ-029 Wakeup: insert qj=3 pending; cdb_valid, cdb_rob_id=3, value=0x10 -> issue a=0x10, one cycle earlier with bypass macro than without.
REQ-030 Same-cycle capture: insert qk=2 pending while CDB broadcasts tag 2 value 9 -> entry issues with b=9, never stalls.
REQ-031 Full: insert 8 entries all pending -> full=1; 9th in_valid ignored; CDB wakes entry 0 -> it issues, full drops next cycle.
REQ-032 Flush/hold: rdy_in=0 for 3 cycles -> outputs frozen; then clear=1 with insert -> all entries gone, cal=0, full=0.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// Shared CPU definitions used by the ALU reservation station: ALU op codes and
// the per-entry payload kept in each reservation-station slot.
package alu_rs_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 4;

    // ALU operation encodings (ADD is all-zero)
    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    // Reservation-station entry payload; ROB tags live alongside because their
    // width is a per-instance parameter.
    typedef struct packed {
        logic            busy;
        logic [OP_W-1:0] op;
        logic [XLEN-1:0] vj;
        logic [XLEN-1:0] vk;
        logic            qj_busy;
        logic            qk_busy;
    } rs_entry_t;

endpackage

// File: rtl/rs_pick.sv
// Lowest-index priority encoder: request vector -> index of first set bit.
module rs_pick #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]         req,
    output logic [$clog2(N)-1:0] idx_c,
    output logic                 valid_c
);

    localparam int unsigned IW = $clog2(N);

    // Scan from the top so the lowest set bit wins
    always_comb begin
        idx_c   = '0;
        valid_c = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx_c   = IW'(i);
                valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands are
// available, snoops the CDB for wakeup, and issues one ready op per cycle.
// Optional macro ALU_RS_WAKEUP_BYPASS_EN lets an entry woken by this cycle's
// CDB issue in the same cycle with cdb_value forwarded into a/b.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int unsigned RS_SIZE   = 8,
    parameter int unsigned ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [OP_W-1:0]      in_op,
    input  logic [XLEN-1:0]      in_vj,
    input  logic [XLEN-1:0]      in_vk,
    input  logic                 in_qj_busy,
    input  logic [ROB_WIDTH-1:0] in_qj,
    input  logic                 in_qk_busy,
    input  logic [ROB_WIDTH-1:0] in_qk,
    input  logic [ROB_WIDTH-1:0] in_rob_id,
    output logic                 full,
    input  logic                 cdb_valid,
    input  logic [ROB_WIDTH-1:0] cdb_rob_id,
    input  logic [XLEN-1:0]      cdb_value,
    output logic                 cal,
    output logic [XLEN-1:0]      a,
    output logic [XLEN-1:0]      b,
    output logic [OP_W-1:0]      alu_op,
    output logic [ROB_WIDTH-1:0] issue_rob_id
);

    localparam int unsigned IDX_W = $clog2(RS_SIZE);

    rs_entry_t            ent     [RS_SIZE];
    logic [ROB_WIDTH-1:0] qj_tag  [RS_SIZE];
    logic [ROB_WIDTH-1:0] qk_tag  [RS_SIZE];
    logic [ROB_WIDTH-1:0] rob_tag [RS_SIZE];

    logic [RS_SIZE-1:0] busy_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic [RS_SIZE-1:0] j_hit;
    logic [RS_SIZE-1:0] k_hit;
    logic [IDX_W-1:0]   free_idx;
    logic               free_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [XLEN-1:0]    a_c;
    logic [XLEN-1:0]    b_c;
    rs_entry_t          ins_entry;

    // Per-entry CDB match and readiness
    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        j_hit     = '0;
        k_hit     = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_vec[i] = ent[i].busy;
            j_hit[i] = ent[i].busy && ent[i].qj_busy && cdb_valid && (qj_tag[i] == cdb_rob_id);
            k_hit[i] = ent[i].busy && ent[i].qk_busy && cdb_valid && (qk_tag[i] == cdb_rob_id);
`ifdef ALU_RS_WAKEUP_BYPASS_EN
            ready_vec[i] = ent[i].busy && (!ent[i].qj_busy || j_hit[i])
                                       && (!ent[i].qk_busy || k_hit[i]);
`else
            ready_vec[i] = ent[i].busy && !ent[i].qj_busy && !ent[i].qk_busy;
`endif
        end
    end

    assign full = &busy_vec;

    rs_pick #(.N(RS_SIZE)) u_pick_free (
        .req     (~busy_vec),
        .idx_c   (free_idx),
        .valid_c (free_valid)
    );

    rs_pick #(.N(RS_SIZE)) u_pick_ready (
        .req     (ready_vec),
        .idx_c   (pick_idx),
        .valid_c (pick_valid)
    );

    // Operands of the selected entry, with same-cycle CDB forwarding when enabled
    always_comb begin
        a_c = ent[pick_idx].vj;
        b_c = ent[pick_idx].vk;
`ifdef ALU_RS_WAKEUP_BYPASS_EN
        if (ent[pick_idx].qj_busy) a_c = cdb_value;
        if (ent[pick_idx].qk_busy) b_c = cdb_value;
`endif
    end

    // Incoming entry with same-cycle CDB capture of a pending operand
    always_comb begin
        ins_entry         = '0;
        ins_entry.busy    = 1'b1;
        ins_entry.op      = in_op;
        ins_entry.vj      = in_vj;
        ins_entry.vk      = in_vk;
        ins_entry.qj_busy = in_qj_busy;
        ins_entry.qk_busy = in_qk_busy;
        if (in_qj_busy && cdb_valid && (in_qj == cdb_rob_id)) begin
            ins_entry.qj_busy = 1'b0;
            ins_entry.vj      = cdb_value;
        end
        if (in_qk_busy && cdb_valid && (in_qk == cdb_rob_id)) begin
            ins_entry.qk_busy = 1'b0;
            ins_entry.vk      = cdb_value;
        end
    end

    // Entry storage, wakeup, issue and insert; clear dominates, rdy_in low holds
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent[i]     <= '0;
                qj_tag[i]  <= '0;
                qk_tag[i]  <= '0;
                rob_tag[i] <= '0;
            end
            cal          <= 1'b0;
            a            <= '0;
            b            <= '0;
            alu_op       <= '0;
            issue_rob_id <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    ent[i].busy <= 1'b0;
                end
                cal <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (j_hit[i]) begin
                        ent[i].qj_busy <= 1'b0;
                        ent[i].vj      <= cdb_value;
                    end
                    if (k_hit[i]) begin
                        ent[i].qk_busy <= 1'b0;
                        ent[i].vk      <= cdb_value;
                    end
                end
                cal <= pick_valid;
                if (pick_valid) begin
                    a                  <= a_c;
                    b                  <= b_c;
                    alu_op             <= ent[pick_idx].op;
                    issue_rob_id       <= rob_tag[pick_idx];
                    ent[pick_idx].busy <= 1'b0;
                end
                if (in_valid && free_valid) begin
                    ent[free_idx]     <= ins_entry;
                    qj_tag[free_idx]  <= in_qj;
                    qk_tag[free_idx]  <= in_qk;
                    rob_tag[free_idx] <= in_rob_id;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios plus randomized traffic against a
// slot-array reference model. Honours ALU_RS_WAKEUP_BYPASS_EN.
module tb_alu_rs;
    import alu_rs_pkg::*;

    localparam int unsigned RS = 8;
    localparam int unsigned RW = 4;
`ifdef ALU_RS_WAKEUP_BYPASS_EN
    localparam bit BYP = 1'b1;
    localparam int WAKE_LAT = 1;
`else
    localparam bit BYP = 1'b0;
    localparam int WAKE_LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst, rdy, clr, in_valid, in_qj_busy, in_qk_busy, cdb_valid;
    logic [3:0]    in_op;
    logic [31:0]   in_vj, in_vk, cdb_value;
    logic [RW-1:0] in_qj, in_qk, in_rob_id, cdb_rob_id;
    logic          full, cal;
    logic [31:0]   a, b;
    logic [3:0]    alu_op;
    logic [RW-1:0] issue_rob_id;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          mb  [RS];
    bit          mjb [RS];
    bit          mkb [RS];
    logic [3:0]  mop [RS];
    logic [31:0] mvj [RS];
    logic [31:0] mvk [RS];
    logic [3:0]  mqj [RS];
    logic [3:0]  mqk [RS];
    logic [3:0]  mrid[RS];
    bit          m_cal;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_op, m_rid;

    always #5 clk = ~clk;

    alu_rs #(.RS_SIZE(RS), .ROB_WIDTH(RW)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear(clr),
        .in_valid(in_valid), .in_op(in_op), .in_vj(in_vj), .in_vk(in_vk),
        .in_qj_busy(in_qj_busy), .in_qj(in_qj), .in_qk_busy(in_qk_busy), .in_qk(in_qk),
        .in_rob_id(in_rob_id), .full(full),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
        .cal(cal), .a(a), .b(b), .alu_op(alu_op), .issue_rob_id(issue_rob_id)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdy = 1'b1; clr = 1'b0; in_valid = 1'b0; in_op = '0; in_vj = '0; in_vk = '0;
        in_qj_busy = 1'b0; in_qj = '0; in_qk_busy = 1'b0; in_qk = '0; in_rob_id = '0;
        cdb_valid = 1'b0; cdb_rob_id = '0; cdb_value = '0;
    endtask

    task automatic set_ins(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                           input logic jb, input logic [3:0] qj, input logic kb,
                           input logic [3:0] qk, input logic [3:0] rid);
        in_valid = 1'b1; in_op = op; in_vj = vj; in_vk = vk;
        in_qj_busy = jb; in_qj = qj; in_qk_busy = kb; in_qk = qk; in_rob_id = rid;
    endtask

    task automatic set_cdb(input logic [3:0] tag, input logic [31:0] val);
        cdb_valid = 1'b1; cdb_rob_id = tag; cdb_value = val;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (2) tick();
        checks++; if (cal !== 1'b0) begin errors++; $display("FAIL reset_cal got %0b want 0", cal); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", full); end
        checks++; if ({a, b, alu_op, issue_rob_id} !== '0) begin
            errors++; $display("FAIL reset_outs got a=%h b=%h op=%h rid=%h want 0", a, b, alu_op, issue_rob_id);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ready_insert();
        idle();
        set_ins(ALU_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd6);
        tick();
        idle();
        checks++; if (cal !== 1'b0) begin errors++; $display("FAIL ready_early got cal=%0b want 0", cal); end
        tick();
        checks++; if (cal !== 1'b1 || a !== 32'd5 || b !== 32'd7 || alu_op !== 4'b0000 || issue_rob_id !== 4'd6) begin
            errors++; $display("FAIL ready_issue got cal=%0b a=%0d b=%0d op=%h rid=%0d want 1 5 7 0 6",
                               cal, a, b, alu_op, issue_rob_id);
        end
        tick();
        checks++; if (cal !== 1'b0) begin errors++; $display("FAIL ready_once got cal=%0b want 0", cal); end
    endtask

    task automatic test_wakeup();
        int n;
        idle();
        set_ins(ALU_SUB, 32'hDEAD, 32'd2, 1'b1, 4'd3, 1'b0, 4'd0, 4'd9);
        tick();
        idle();
        set_cdb(4'd3, 32'h10);
        tick();
        idle();
        n = 1;
        while (cal !== 1'b1 && n < 4) begin tick(); n++; end
        checks++; if (n != WAKE_LAT) begin errors++; $display("FAIL wakeup_latency got %0d want %0d", n, WAKE_LAT); end
        checks++; if (cal !== 1'b1 || a !== 32'h10 || b !== 32'd2 || alu_op !== 4'd1 || issue_rob_id !== 4'd9) begin
            errors++; $display("FAIL wakeup_issue got cal=%0b a=%h b=%h op=%h rid=%0d want 1 10 2 1 9",
                               cal, a, b, alu_op, issue_rob_id);
        end
        tick();
    endtask

    task automatic test_same_cycle_capture();
        idle();
        set_ins(ALU_OR, 32'd4, 32'hBAD, 1'b0, 4'd0, 1'b1, 4'd2, 4'd11);
        set_cdb(4'd2, 32'd9);
        tick();
        idle();
        tick();
        checks++; if (cal !== 1'b1 || a !== 32'd4 || b !== 32'd9 || issue_rob_id !== 4'd11) begin
            errors++; $display("FAIL capture_issue got cal=%0b a=%0d b=%0d rid=%0d want 1 4 9 11",
                               cal, a, b, issue_rob_id);
        end
        tick();
    endtask

    task automatic test_full();
        int n;
        for (int i = 0; i < RS; i++) begin
            idle();
            set_ins(ALU_XOR, 32'd0, 32'(i), 1'b1, (i == 0) ? 4'd1 : 4'd12, 1'b0, 4'd0, 4'(i));
            tick();
        end
        idle();
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_set got %0b want 1", full); end
        set_ins(ALU_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd13);
        tick();
        idle();
        checks++; if (full !== 1'b1 || cal !== 1'b0) begin
            errors++; $display("FAIL full_ninth got full=%0b cal=%0b want 1 0", full, cal);
        end
        tick();
        checks++; if (cal !== 1'b0) begin errors++; $display("FAIL full_ignored got cal=%0b want 0", cal); end
        set_cdb(4'd1, 32'h55);
        tick();
        idle();
        n = 1;
        while (cal !== 1'b1 && n < 4) begin tick(); n++; end
        checks++; if (n != WAKE_LAT || a !== 32'h55 || issue_rob_id !== 4'd0) begin
            errors++; $display("FAIL full_wake got lat=%0d a=%h rid=%0d want %0d 55 0", n, a, issue_rob_id, WAKE_LAT);
        end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_drop got %0b want 0", full); end
        tick();
        checks++; if (cal !== 1'b0 || full !== 1'b0) begin
            errors++; $display("FAIL full_after got cal=%0b full=%0b want 0 0", cal, full);
        end
    endtask

    task automatic test_flush_hold();
        idle();
        set_ins(ALU_AND, 32'hAA, 32'hBB, 1'b0, 4'd0, 1'b0, 4'd0, 4'd5);
        tick();
        idle();
        tick();
        checks++; if (cal !== 1'b1 || a !== 32'hAA) begin
            errors++; $display("FAIL hold_pre got cal=%0b a=%h want 1 aa", cal, a);
        end
        rdy = 1'b0;
        set_ins(ALU_ADD, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7);
        set_cdb(4'd12, 32'h77);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (cal !== 1'b1 || a !== 32'hAA || b !== 32'hBB || issue_rob_id !== 4'd5 || full !== 1'b0) begin
                errors++; $display("FAIL hold_frozen cyc %0d got cal=%0b a=%h b=%h rid=%0d full=%0b want 1 aa bb 5 0",
                                   c, cal, a, b, issue_rob_id, full);
            end
        end
        rdy = 1'b1;
        clr = 1'b1;
        tick();
        checks++; if (cal !== 1'b0 || full !== 1'b0) begin
            errors++; $display("FAIL flush_now got cal=%0b full=%0b want 0 0", cal, full);
        end
        idle();
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (cal !== 1'b0 || full !== 1'b0) begin
                errors++; $display("FAIL flush_empty cyc %0d got cal=%0b full=%0b want 0 0", c, cal, full);
            end
        end
    endtask

    task automatic test_reset_midrun();
        idle();
        for (int i = 0; i < 3; i++) begin
            set_ins(ALU_SLT, 32'd3, 32'd4, 1'b1, 4'd15, 1'b0, 4'd0, 4'(i));
            tick();
        end
        set_ins(ALU_ADD, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4);
        tick();
        idle();
        tick();
        checks++; if (cal !== 1'b1 || a !== 32'd1) begin
            errors++; $display("FAIL midrst_pre got cal=%0b a=%0d want 1 1", cal, a);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (cal !== 1'b0 || full !== 1'b0 || a !== 32'd0) begin
            errors++; $display("FAIL midrst_async got cal=%0b full=%0b a=%0d want 0 0 0", cal, full, a);
        end
        tick();
        rst = 1'b0;
        set_cdb(4'd15, 32'h99);
        for (int c = 0; c < 3; c++) begin
            tick();
            idle();
            checks++; if (cal !== 1'b0 || full !== 1'b0) begin
                errors++; $display("FAIL midrst_stale cyc %0d got cal=%0b full=%0b want 0 0", c, cal, full);
            end
        end
    endtask

    // Reference: apply one clock edge of RS behaviour to the model slots
    task automatic model_edge();
        int  sel = -1;
        int  fr = -1;
        int  nbusy = 0;
        bit  hj, hk;
        if (!rdy) return;
        if (clr) begin
            for (int i = 0; i < RS; i++) mb[i] = 1'b0;
            m_cal = 1'b0;
            return;
        end
        for (int i = 0; i < RS; i++) begin
            if (mb[i]) nbusy++;
            else if (fr < 0) fr = i;
            hj = mjb[i] && cdb_valid && (mqj[i] == cdb_rob_id);
            hk = mkb[i] && cdb_valid && (mqk[i] == cdb_rob_id);
            if (sel < 0 && mb[i] && (!mjb[i] || (BYP && hj)) && (!mkb[i] || (BYP && hk))) sel = i;
        end
        m_cal = (sel >= 0);
        if (sel >= 0) begin
            m_a   = mjb[sel] ? cdb_value : mvj[sel];
            m_b   = mkb[sel] ? cdb_value : mvk[sel];
            m_op  = mop[sel];
            m_rid = mrid[sel];
        end
        for (int i = 0; i < RS; i++) begin
            if (mb[i] && mjb[i] && cdb_valid && mqj[i] == cdb_rob_id) begin mjb[i] = 1'b0; mvj[i] = cdb_value; end
            if (mb[i] && mkb[i] && cdb_valid && mqk[i] == cdb_rob_id) begin mkb[i] = 1'b0; mvk[i] = cdb_value; end
        end
        if (sel >= 0) mb[sel] = 1'b0;
        if (in_valid && nbusy < RS) begin
            mb[fr] = 1'b1; mop[fr] = in_op; mrid[fr] = in_rob_id;
            mqj[fr] = in_qj; mqk[fr] = in_qk;
            mjb[fr] = in_qj_busy; mvj[fr] = in_vj;
            mkb[fr] = in_qk_busy; mvk[fr] = in_vk;
            if (in_qj_busy && cdb_valid && in_qj == cdb_rob_id) begin mjb[fr] = 1'b0; mvj[fr] = cdb_value; end
            if (in_qk_busy && cdb_valid && in_qk == cdb_rob_id) begin mkb[fr] = 1'b0; mvk[fr] = cdb_value; end
        end
    endtask

    task automatic test_random();
        bit exp_full;
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < RS; i++) mb[i] = 1'b0;
        m_cal = 1'b0;
        for (int c = 0; c < 800; c++) begin
            rdy        = ($urandom % 10) != 0;
            clr        = ($urandom % 40) == 0;
            in_valid   = ($urandom % 10) < 6;
            in_op      = 4'($urandom % 10);
            in_vj      = $urandom;
            in_vk      = $urandom;
            in_qj_busy = ($urandom % 2) == 0;
            in_qj      = 4'($urandom % 8);
            in_qk_busy = ($urandom % 3) == 0;
            in_qk      = 4'($urandom % 8);
            in_rob_id  = 4'($urandom);
            cdb_valid  = ($urandom % 2) == 0;
            cdb_rob_id = 4'($urandom % 8);
            cdb_value  = $urandom;
            model_edge();
            tick();
            exp_full = 1'b1;
            for (int i = 0; i < RS; i++) if (!mb[i]) exp_full = 1'b0;
            checks++; if (cal !== m_cal) begin
                errors++; $display("FAIL rand_cal cyc %0d got %0b want %0b", c, cal, m_cal);
            end
            checks++; if (full !== exp_full) begin
                errors++; $display("FAIL rand_full cyc %0d got %0b want %0b", c, full, exp_full);
            end
            if (m_cal) begin
                checks++; if (a !== m_a || b !== m_b || alu_op !== m_op || issue_rob_id !== m_rid) begin
                    errors++; $display("FAIL rand_issue cyc %0d got a=%h b=%h op=%h rid=%h want %h %h %h %h",
                                       c, a, b, alu_op, issue_rob_id, m_a, m_b, m_op, m_rid);
                end
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_ready_insert();
        test_wakeup();
        test_same_cycle_capture();
        test_full();
        test_flush_hold();
        test_reset_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
